// File: rtl/log_dump_reader_if.sv
// Log RAM read port plus byte stream toward the UART transmitter.
// The master side is the dump reader; the slave side is the RAM/transmitter pair.
interface log_dump_reader_if #(
  parameter int RAM_WIDTH = 32,
  parameter int AW        = 15
);
  logic [AW-1:0]        o_read_adrs;
  logic                 o_en_read;
  logic [RAM_WIDTH-1:0] i_data_ram;
  logic [7:0]           o_byte;
  logic                 o_byte_valid;
  logic                 i_byte_ready;

  modport master (
    output o_read_adrs, o_en_read, o_byte, o_byte_valid,
    input  i_data_ram, i_byte_ready
  );

  modport slave (
    input  o_read_adrs, o_en_read, o_byte, o_byte_valid,
    output i_data_ram, i_byte_ready
  );
endinterface

// File: rtl/log_dump_reader.sv
// Streams log RAM words out as bytes (MSB byte first) toward a UART transmitter.
// Define LOG_DUMP_HEADER_EN to prefix each dump with A5 5A count[15:8] count[7:0].
//
// state | meaning
// IDLE  | waiting for i_start
// HDR   | sending the 4-byte header (LOG_DUMP_HEADER_EN only)
// REQ   | one-cycle RAM read request at the current word index
// WAIT  | RAM data arrives, captured into the holding register
// SEND  | shifting the held word out, one byte per accepted transfer
// DONE  | one-cycle o_done pulse, then back to IDLE
module log_dump_reader #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32768,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [AW:0]       i_num_words,
  output logic              o_busy,
  output logic              o_done,
  log_dump_reader_if.master bus
);

  localparam int BYTES = RAM_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTES - 1);
  localparam logic [AW:0]    DEPTH_MAX = (AW+1)'(RAM_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
`ifdef LOG_DUMP_HEADER_EN
  localparam logic [2:0] S_HDR  = 3'd1;
`endif
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]           state;
  logic [AW:0]          count;
  logic [AW-1:0]        index;
  logic [AW-1:0]        adrs_q;
  logic [RAM_WIDTH-1:0] hold;
  logic [BCW-1:0]       byte_cnt;
  logic [AW:0]          num_clamped;
  logic [AW:0]          index_next;
  logic                 xfer;

  assign num_clamped = (i_num_words > DEPTH_MAX) ? DEPTH_MAX : i_num_words;
  assign index_next  = {1'b0, index} + (AW+1)'(1);
  assign xfer        = bus.o_byte_valid & bus.i_byte_ready;

  // A zero-length dump still passes through REQ, but never touches the RAM.
  assign bus.o_en_read   = (state == S_REQ) && (count != '0);
  assign bus.o_read_adrs = bus.o_en_read ? index : adrs_q;
  assign o_busy          = (state != S_IDLE);
  assign o_done          = (state == S_DONE);

`ifdef LOG_DUMP_HEADER_EN
  logic [1:0]  hdr_cnt;
  logic [15:0] count16;
  logic [7:0]  hdr_byte;

  assign count16 = 16'(count);

  always_comb begin
    hdr_byte = count16[7:0];
    case (hdr_cnt)
      2'd3:    hdr_byte = 8'hA5;
      2'd2:    hdr_byte = 8'h5A;
      2'd1:    hdr_byte = count16[15:8];
      default: hdr_byte = count16[7:0];
    endcase
  end

  assign bus.o_byte_valid = (state == S_SEND) || (state == S_HDR);
  assign bus.o_byte       = (state == S_HDR) ? hdr_byte : hold[RAM_WIDTH-1 -: 8];
`else
  assign bus.o_byte_valid = (state == S_SEND);
  assign bus.o_byte       = hold[RAM_WIDTH-1 -: 8];
`endif

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_IDLE;
      count    <= '0;
      index    <= '0;
      adrs_q   <= '0;
      hold     <= '0;
      byte_cnt <= '0;
`ifdef LOG_DUMP_HEADER_EN
      hdr_cnt  <= '0;
`endif
    end else if (i_abort && (state != S_IDLE) && (state != S_DONE)) begin
      state <= S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            count <= num_clamped;
            index <= '0;
`ifdef LOG_DUMP_HEADER_EN
            hdr_cnt <= 2'd3;
            state   <= S_HDR;
`else
            state   <= S_REQ;
`endif
          end
        end
`ifdef LOG_DUMP_HEADER_EN
        S_HDR: begin
          if (xfer) begin
            if (hdr_cnt == 2'd0) state <= S_REQ;
            else                 hdr_cnt <= hdr_cnt - 2'd1;
          end
        end
`endif
        S_REQ: begin
          if (count == '0) begin
            state <= S_DONE;
          end else begin
            adrs_q <= index;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          hold     <= bus.i_data_ram;
          byte_cnt <= BYTE_LAST;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            hold <= hold << 8;
            if (byte_cnt == '0) begin
              if (index_next < count) begin
                index <= index_next[AW-1:0];
                state <= S_REQ;
              end else begin
                state <= S_DONE;
              end
            end else begin
              byte_cnt <= byte_cnt - BCW'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
